// File: rtl/dac_write_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_pkg: shared MCP4725 constants and scheduler state type.  rev 1.0
// ---------------------------------------------------------------------------
package dac_pkg;

  // Fast-mode write command bits C2:C1.
  localparam logic [1:0] C_CMD_FAST = 2'b00;

  typedef enum logic [1:0] {
    PD_NORMAL = 2'b00,
    PD_1K     = 2'b01,
    PD_100K   = 2'b10,
    PD_500K   = 2'b11
  } pd_t;

  localparam logic [6:0] C_BASE_ADDR = 7'h60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_write_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_write_scheduler_if: source requests and write-engine handshake.  rev 1.0
// ---------------------------------------------------------------------------
interface dac_write_scheduler_if #(
  parameter int N = 2
);
  logic [N-1:0]    req;
  logic [12*N-1:0] req_code;
  logic [2*N-1:0]  req_pd;
  logic [N-1:0]    grant;
  logic            wr_start;
  logic [6:0]      wr_addr;
  logic [11:0]     wr_code;
  logic [1:0]      wr_pd;
  logic            wr_busy;
  logic            wr_done;
  logic            wr_nack;
  logic            err;
  logic [1:0]      err_src;
  logic            active;

  modport master (
    input  req, req_code, req_pd, wr_busy, wr_done, wr_nack,
    output grant, wr_start, wr_addr, wr_code, wr_pd, err, err_src, active
  );

  modport slave (
    output req, req_code, req_pd, wr_busy, wr_done, wr_nack,
    input  grant, wr_start, wr_addr, wr_code, wr_pd, err, err_src, active
  );
endinterface
`default_nettype wire

// File: rtl/dac_write_scheduler_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr.  rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/dac_write_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_write_scheduler: arbitrates DAC writes onto one I2C write engine. rev 1.0
// ---------------------------------------------------------------------------
module dac_write_scheduler
  import dac_pkg::*;
#(
  parameter int         N         = 2,
  parameter logic [6:0] BASE_ADDR = C_BASE_ADDR,
  parameter int         MIN_GAP   = 25,
  parameter int         MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_write_scheduler_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t        r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_sel;
  logic [RW-1:0] r_retry_cnt;
  logic          r_retry_pend;
  logic [GW-1:0] r_gap;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_valid;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_sel        <= '0;
      r_retry_cnt  <= '0;
      r_retry_pend <= 1'b0;
      r_gap        <= '0;
      bus.grant    <= '0;
      bus.wr_start <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_code  <= '0;
      bus.wr_pd    <= '0;
      bus.err      <= 1'b0;
      bus.err_src  <= '0;
      bus.active   <= 1'b0;
    end else begin
      bus.grant    <= '0;
      bus.wr_start <= 1'b0;
      bus.err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            bus.grant   <= w_grant;
            bus.wr_addr <= BASE_ADDR + 7'(w_idx);
            bus.wr_code <= bus.req_code[12*w_idx +: 12];
            bus.wr_pd   <= bus.req_pd[2*w_idx +: 2];
            bus.active  <= 1'b1;
            r_sel       <= w_idx;
            r_rr_ptr    <= (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.wr_busy) begin
            bus.wr_start <= 1'b1;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.wr_done) begin
            r_gap   <= GW'(MIN_GAP);
            r_state <= ST_GAP;
            if (!bus.wr_nack) begin
              r_retry_cnt  <= '0;
              r_retry_pend <= 1'b0;
            end else if (r_retry_cnt < RW'(MAX_RETRY)) begin
              r_retry_cnt  <= r_retry_cnt + 1'b1;
              r_retry_pend <= 1'b1;
            end else begin
              bus.err      <= 1'b1;
              bus.err_src  <= 2'(r_sel);
              r_retry_cnt  <= '0;
              r_retry_pend <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          // Gap occupies exactly MIN_GAP cycles; latched wr_* stay put for a retry.
          if (r_gap == GW'(1)) begin
            r_retry_pend <= 1'b0;
            if (r_retry_pend) begin
              r_state <= ST_ISSUE;
            end else begin
              bus.active <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/dac_write_scheduler.md
Name: dac_write_scheduler

Overview:
Arbitrates DAC update requests from up to N waveform/sample sources onto the single I2C fast-write engine that drives the MCP4725 bus (SDA/SCL). Each requester owns one MCP4725 device, addressed as BASE_ADDR + index. The block latches a request and issues one write transaction to the engine. It retries on NACK, enforces a minimum bus-idle gap between transactions, and reports per-source errors. It sits between the waveform table/trigger logic and the I2C write engine.

Parameters:
N, 2, number of requesters (1..4)
BASE_ADDR, 7'h60, 7-bit I2C address of requester 0; requester i uses BASE_ADDR+i
MIN_GAP, 25, clk cycles of enforced idle after wr_done before the next wr_start (>=1)
MAX_RETRY, 2, re-issues allowed after a NACK before the request is dropped

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  N  per-source request level; held with data stable until grant
req_code  in  12*N  DAC code, source i at [12i+11:12i]
req_pd  in  2*N  power-down bits PD1:PD0, source i at [2i+1:2i]
grant  out  N  one-hot, 1-cycle pulse when the source's request is latched
wr_start  out  1  1-cycle pulse to the write engine
wr_addr  out  7  device address for the current transaction
wr_code  out  12  DAC code for the current transaction
wr_pd  out  2  power-down bits for the current transaction
wr_busy  in  1  engine is mid-transaction
wr_done  in  1  1-cycle pulse at STOP completion
wr_nack  in  1  valid only with wr_done; 1 = any ACK slot was NACKed
err  out  1  1-cycle pulse when a request is dropped after retries
err_src  out  2  index of the source that was dropped; held until the next err
active  out  1  high from latch until GAP expires

Behaviour:
- Reset: FSM=IDLE, rr_ptr=0, retry_cnt=0. grant, wr_start, err and active are 0. wr_addr, wr_code, wr_pd and err_src are 0.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: if any req bit is set, pick the first set bit searching from rr_ptr upward, with wrap.
  - Latch code, pd and address into the wr_* registers.
  - Pulse grant[sel] for 1 cycle, set rr_ptr = sel+1 mod N, go to ISSUE.
  - Latency: req high in cycle t gives grant in cycle t+1.
- ISSUE: if wr_busy=0, pulse wr_start and go to WAIT. Otherwise hold in ISSUE.
- WAIT: wr_start is never re-asserted here. On wr_done:
  - nack=0: retry_cnt=0, go to GAP.
  - nack=1 and retry_cnt<MAX_RETRY: retry_cnt++, go to GAP, then re-issue the same latched data (no new grant).
  - nack=1 and retry_cnt==MAX_RETRY: pulse err, set err_src=sel, retry_cnt=0, go to GAP, drop the request.
- GAP: count MIN_GAP cycles.
  - Then go to ISSUE if a retry is pending, else to IDLE.
  - Arbitration resumes in IDLE the cycle after GAP ends.
- wr_* outputs are stable from latch until leaving GAP. The engine samples them on wr_start.
- Fairness: with all sources continuously requesting, grants rotate 0,1,..,N-1,0. No source waits more than N-1 transactions.
- Source requirements: a source deasserts req after grant or re-raises it for the next sample. Requests seen in the grant cycle are not double-counted because the FSM has left IDLE.
- wr_done outside WAIT is ignored. The wr_nack bit is ignored without wr_done.
- rst mid-transaction: FSM returns to IDLE immediately and the pending request is lost. The engine is reset by the same rst.
- Width rules:
  - Gap counter is clog2(MIN_GAP+1) bits.
  - retry_cnt is clog2(MAX_RETRY+1) bits.
  - Address add is 7-bit modulo.

Decomposition:
- Shared package dac_pkg holds:
  - the MCP4725 fast-mode command constants (C2:C1=00);
  - the PD encodings (00 normal, 01 1k, 10 100k, 11 500k);
  - the default BASE_ADDR;
  - the FSM state enum.
- One sub-module: rr_arbiter (N-bit request, rr_ptr in, one-hot grant plus index out, purely combinational priority rotate), instantiated once.

Test Plan:
- Single request, source0 code 12'h138, pd 00 → grant[0] at t+1, wr_start at t+2 with wr_addr 7'h60, wr_code 12'h138; done(nack=0) → active low after exactly 25 cycles.
- Both sources hold req with codes 12'h564 and 12'hE15 → grant sequence 0,1,0,1; wr_addr alternates 7'h60/7'h61; consecutive wr_start pulses spaced ≥ 25 cycles after each wr_done.
- Source1 request with wr_nack=1 on every done → wr_start issued 3 times with identical data; then err pulse, err_src=1; a single grant only.
- NACK once then ACK → 2 wr_start pulses, no err, retry_cnt back to 0.
- wr_busy held high when ISSUE is entered → wr_start withheld until busy drops, then fires on the next cycle.
- rst asserted during WAIT → next cycle all outputs are at reset values; a fresh request afterwards is granted normally, starting from source 0.
